// File: rtl/mips_pkg.sv
// Shared MDU encodings for the MIPS MCU execute stage.
package mips_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  localparam int MDU_ITERS = 32;

  // Control captured at accept; result signs are decided from the operands then.
  typedef struct packed {
    logic is_div;
    logic neg_lo;
  } mdu_ctl_t;

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; gives magnitudes of signed operands and re-signs results.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU complete in one cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic               done_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   dsr_q;
  mdu_ctl_t           ctl_q, ctl_d;
  logic               no_div_path;

  mdu_op_e op_e;
  logic    sgn;
  assign op_e = mdu_op_e'(op);
  assign sgn  = op_is_signed(op_e);
  assign busy = (state_q != S_IDLE);

  // [0]=rs, [1]=rt
  logic [1:0][WIDTH-1:0] opnd_raw, opnd_mag;
  logic [1:0]            opnd_neg;
  assign opnd_raw = {rt_data, rs_data};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    assign opnd_neg[g] = sgn & opnd_raw[g][WIDTH-1];
    mdu_sign_fix #(.W(WIDTH)) u_fix (
      .val (opnd_raw[g]),
      .neg (opnd_neg[g]),
      .res (opnd_mag[g])
    );
  end

  assign ctl_d.is_div = op_e[1];
  assign ctl_d.neg_lo = opnd_neg[0] ^ opnd_neg[1];

  // Shift-add: multiplier sits in acc low half and drains out as the product fills in.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? dsr_q : '0)};
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  logic [2*WIDTH-1:0] prod_fix, fix_val, calc_step;
  mdu_sign_fix #(.W(2*WIDTH)) u_prod_fix (
    .val (acc_q),
    .neg (ctl_q.neg_lo),
    .res (prod_fix)
  );

`ifdef MDU_DIV_EN
  logic neg_rem_q, div0_q;

  // Restoring step: remainder in acc high half, dividend shifts out / quotient shifts in below.
  logic [WIDTH:0]     div_rq, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_step;
  assign div_rq   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_rq - {1'b0, dsr_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_step = {(div_ge ? div_diff[WIDTH-1:0] : div_rq[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  logic [WIDTH-1:0] quo_fix, rem_fix;
  mdu_sign_fix #(.W(WIDTH)) u_quo_fix (
    .val (acc_q[WIDTH-1:0]),
    .neg (ctl_q.neg_lo),
    .res (quo_fix)
  );
  mdu_sign_fix #(.W(WIDTH)) u_rem_fix (
    .val (acc_q[2*WIDTH-1:WIDTH]),
    .neg (neg_rem_q),
    .res (rem_fix)
  );

  // Divide by zero: remainder already equals the dividend, only LO needs forcing.
  assign fix_val     = ctl_q.is_div ? {rem_fix, (div0_q ? {WIDTH{1'b1}} : quo_fix)} : prod_fix;
  assign calc_step   = ctl_q.is_div ? div_step : mul_step;
  assign no_div_path = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      neg_rem_q <= opnd_neg[0];
      div0_q    <= (rt_data == '0);
    end
  end
`else
  assign fix_val     = prod_fix;
  assign calc_step   = mul_step;
  assign no_div_path = ctl_q.is_div;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: begin
        if (no_div_path) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end
      // Two FIX cycles: the 2*WIDTH negate is registered before it reaches hi/lo.
      S_FIX: begin
        if (cnt_q != '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      dsr_q <= '0;
      ctl_q <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q <= '0;
            ctl_q <= ctl_d;
            if (ctl_d.is_div) begin
              acc_q <= {{WIDTH{1'b0}}, opnd_mag[0]};
              dsr_q <= opnd_mag[1];
            end else begin
              acc_q <= {{WIDTH{1'b0}}, opnd_mag[1]};
              dsr_q <= opnd_mag[0];
            end
          end else begin
            if (hi_we) hi <= wr_data;
            if (lo_we) lo <= wr_data;
          end
        end
        S_CALC: begin
          cnt_q <= (state_d == S_CALC) ? cnt_q + CW'(1) : '0;
          acc_q <= calc_step;
        end
        S_FIX: begin
          if (cnt_q == '0) begin
            cnt_q <= cnt_q + CW'(1);
            acc_q <= fix_val;
          end else begin
            cnt_q <= '0;
            hi    <= acc_q[2*WIDTH-1:WIDTH];
            lo    <= acc_q[WIDTH-1:0];
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push expected hi/lo/latency, a monitor checks on done.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MDU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic         tb_clk = 1'b0;
  logic         rst, start, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data, wr_data, hi, lo;

  always #5 tb_clk = ~tb_clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(tb_clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           total = 0, bad = 0, cyc = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0;

  always @(posedge tb_clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  exp_t e;
  always @(posedge tb_clk) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want done=0 (cyc %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("res_hi", hi, e.hi);
        check("res_lo", lo, e.lo);
        check("latency", W'(cyc - e.acc), W'(e.lat));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input int lat,
                       input bit mthi);
    @(negedge tb_clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    if (mthi) begin hi_we = 1'b1; wr_data = 32'h1234_5678; end
    sb.push_back('{hi: ehi, lo: elo, acc: cyc + 1, lat: lat});
    m_hi = ehi; m_lo = elo;
    @(negedge tb_clk);
    start = 1'b0;
  endtask

  // Without the divider a divide completes in one cycle and leaves hi/lo alone.
  task automatic issue_div(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ehi, input logic [W-1:0] elo);
    if (DIV_ON) issue(o, a, b, ehi, elo, 34, 1'b0);
    else        issue(o, a, b, m_hi, m_lo, 1, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge tb_clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  int berr;
  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
    repeat (3) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);

    // MULTU with busy held across the whole latency
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 34, 1'b0);
    berr = 0;
    for (int i = 0; i < 34; i++) begin
      if (busy !== 1'b1) berr++;
      @(negedge tb_clk);
    end
    check("busy_during", W'(berr), '0);
    check("busy_after", W'(busy), '0);

    // signed products
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 1'b0);
    wait_idle();
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34, 1'b0);
    wait_idle();

    // divides, including divide by zero and the overflow wrap
    issue_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle();
    issue_div(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    wait_idle();
    issue_div(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_idle();
    issue_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    wait_idle();
    issue_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_idle();
    issue_div(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    wait_idle();

    // start while busy is dropped
    issue(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 34, 1'b0);
    repeat (4) @(negedge tb_clk);
    rs_data = 32'd9; start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    wait_idle();

    // reset mid-operation aborts with no result
    @(negedge tb_clk);
    op = OP_MULTU; rs_data = 32'd7; rt_data = 32'd7; start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    repeat (9) @(negedge tb_clk);
    rst = 1'b1;
    @(negedge tb_clk);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_hi", hi, '0);
    check("abort_lo", lo, '0);
    rst = 1'b0; m_hi = '0; m_lo = '0;
    repeat (40) @(negedge tb_clk);
    check("abort_idle", W'(busy), '0);

    // MTHI / MTLO while idle
    hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
    @(negedge tb_clk);
    hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'hCAFE_CAFE;
    @(negedge tb_clk);
    lo_we = 1'b0;
    check("mthi", hi, 32'hDEAD_BEEF);
    check("mtlo", lo, 32'hCAFE_CAFE);

    // MTHI with start and while busy is ignored
    issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34, 1'b1);
    repeat (5) @(negedge tb_clk);
    check("mthi_busy", hi, 32'hDEAD_BEEF);
    hi_we = 1'b0;
    wait_idle();

    // back-to-back: second start lands in the done cycle
    issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 34, 1'b0);
    repeat (33) @(negedge tb_clk);
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 34, 1'b0);
    wait_idle();

    repeat (3) @(negedge tb_clk);
    check("sb_empty", W'(sb.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
